// File: rtl/approx_add_pkg.sv
// approx_add_pkg: shared types and helpers for the approximate pipelined adder.
//   mode_t    - runtime approximation mode carried with each operand pair
//   seg_width - width of one carry segment of the exact upper part
//   DEF_*     - default parameter values for the adder
package approx_add_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOA   = 2'd1,
        MODE_TRUNC = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_APPROX_LSB = 4;
    localparam int DEF_STAGES     = 2;

    // ceil(u / stages); later segments are clamped to what is left of u
    function automatic int seg_width(input int u, input int stages);
        return (stages > 0) ? (u + stages - 1) / stages : u;
    endfunction

endpackage

// File: rtl/approx_lower_unit.sv
// approx_lower_unit: combinational lower-part adder and carry generator.
//   i_a, i_b - low K bits of the operands
//   i_mode   - approximation mode
//   o_sum    - low K bits of the result
//   o_cin    - carry passed into the exact upper part
module approx_lower_unit
    import approx_add_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [K-1:0] i_a,
    input  logic [K-1:0] i_b,
    input  mode_t        i_mode,
    output logic [K-1:0] o_sum,
    output logic         o_cin
);

    always_comb begin
        o_sum = '0;
        o_cin = 1'b0;
        case (i_mode)
            MODE_LOA: begin
                // OR approximates the sum; the top-bit AND recovers the likeliest carry
                o_sum = i_a | i_b;
                o_cin = i_a[K-1] & i_b[K-1];
            end
            MODE_TRUNC: begin
                // constant half-range compensation for the dropped bits
                o_sum        = '0;
                o_sum[K-1]   = 1'b1;
                o_cin        = 1'b0;
            end
            default: begin
                {o_cin, o_sum} = {1'b0, i_a} + {1'b0, i_b};
            end
        endcase
    end

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined unsigned WIDTH-bit adder with an approximate
// lower part and an exact upper part split into STAGES registered carry
// segments, behind a valid/ready stream.
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid, in_ready   - input handshake
//   A, B, mode           - operands and approximation mode (travel together)
//   out_valid, out_ready - output handshake
//   O                    - WIDTH+1 bit sum
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int APPROX_LSB = DEF_APPROX_LSB,
    parameter int STAGES     = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   O
);

    localparam int K  = APPROX_LSB;
    localparam int U  = WIDTH - APPROX_LSB;
    localparam int SW = seg_width(U, STAGES);

    if (APPROX_LSB < 0 || APPROX_LSB >= WIDTH) begin : g_err_lsb
        $error("approx_add_pipe: APPROX_LSB must be in 0..WIDTH-1");
    end
    if (STAGES < 1 || STAGES > U) begin : g_err_stages
        $error("approx_add_pipe: STAGES must be in 1..WIDTH-APPROX_LSB");
    end

    logic           w_en;
    logic           w_cin;
    logic [WIDTH:0] w_low_word;

    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    if (K > 0) begin : g_lower
        logic [K-1:0] w_lo_sum;

        approx_lower_unit #(
            .K(K)
        ) u_lower (
            .i_a   (A[K-1:0]),
            .i_b   (B[K-1:0]),
            .i_mode(mode_t'(mode)),
            .o_sum (w_lo_sum),
            .o_cin (w_cin)
        );

        assign w_low_word = {{(WIDTH + 1 - K){1'b0}}, w_lo_sum};
    end else begin : g_nolower
        assign w_cin      = 1'b0;
        assign w_low_word = '0;
    end

    // Inputs of each pipeline stage: index 0 is the unregistered input side,
    // index s+1 is driven by the registers after stage s.
    logic [U-1:0]   w_a_in   [STAGES];
    logic [U-1:0]   w_b_in   [STAGES];
    logic           w_c_in   [STAGES];
    logic [WIDTH:0] w_res_in [STAGES];
    logic           w_v_in   [STAGES];

    assign w_a_in[0]   = A[WIDTH-1:K];
    assign w_b_in[0]   = B[WIDTH-1:K];
    assign w_c_in[0]   = w_cin;
    assign w_res_in[0] = w_low_word;
    assign w_v_in[0]   = in_valid;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Segment bounds; with ceil-sized segments the tail may be empty,
        // in which case the stage only forwards the carry.
        localparam int LO  = (s * SW < U) ? s * SW : U;
        localparam int HI  = ((s + 1) * SW < U) ? (s + 1) * SW : U;
        localparam int SWD = HI - LO;

        localparam logic [U:0]   L_ONE     = {{U{1'b0}}, 1'b1};
        localparam logic [U:0]   L_CBIT    = L_ONE << SWD;
        localparam logic [U:0]   L_SMASK_X = L_CBIT - L_ONE;
        localparam logic [U:0]   L_DONE_X  = (L_ONE << HI) - L_ONE;
        localparam logic [U-1:0] L_SMASK   = L_SMASK_X[U-1:0];
        localparam logic [U-1:0] L_KEEP    = ~L_DONE_X[U-1:0];

        logic [U-1:0]   w_aseg;
        logic [U-1:0]   w_bseg;
        logic [U:0]     w_segsum;
        logic           w_cout;
        logic [WIDTH:0] w_res_o;

        assign w_aseg   = (w_a_in[s] >> LO) & L_SMASK;
        assign w_bseg   = (w_b_in[s] >> LO) & L_SMASK;
        assign w_segsum = {1'b0, w_aseg} + {1'b0, w_bseg} + {{U{1'b0}}, w_c_in[s]};
        assign w_cout   = |(w_segsum & L_CBIT);
        assign w_res_o  = w_res_in[s]
                        | ({{(K + 1){1'b0}}, w_segsum[U-1:0] & L_SMASK} << (K + LO));

        if (s < STAGES - 1) begin : g_mid
            logic [U-1:0]   r_a;
            logic [U-1:0]   r_b;
            logic           r_c;
            logic [WIDTH:0] r_res;
            logic           r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_c   <= 1'b0;
                    r_res <= '0;
                    r_v   <= 1'b0;
                end else if (w_en) begin
                    // consumed operand bits are dropped; the rest is skewed on
                    r_a   <= w_a_in[s] & L_KEEP;
                    r_b   <= w_b_in[s] & L_KEEP;
                    r_c   <= w_cout;
                    r_res <= w_res_o;
                    r_v   <= w_v_in[s];
                end
            end

            assign w_a_in[s+1]   = r_a;
            assign w_b_in[s+1]   = r_b;
            assign w_c_in[s+1]   = r_c;
            assign w_res_in[s+1] = r_res;
            assign w_v_in[s+1]   = r_v;
        end else begin : g_out
            logic [WIDTH:0] r_res;
            logic           r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_res <= '0;
                    r_v   <= 1'b0;
                end else if (w_en) begin
                    r_res <= w_res_o | {w_cout, {WIDTH{1'b0}}};
                    r_v   <= w_v_in[s];
                end
            end

            assign O         = r_res;
            assign out_valid = r_v;
        end
    end

endmodule
